// File: rtl/ad5541_dac_sched_pkg.sv
// Shared definitions for the AD5541 DAC update scheduler: FSM states, DAC word width
// and the index-width helper used to size the grant id.
package ad5541_pkg;

  localparam int DAC_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_END,
    S_STROBE,
    S_GAP
  } state_t;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/ad5541_dac_sched_rr_arbiter.sv
// Combinational round-robin select: picks the first asserted request at or after rr_ptr,
// wrapping modulo NUM_REQ, and reports it both one-hot and as an index.
module rr_arbiter
  import ad5541_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int GW      = clog2_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      grant_idx
);

  logic [GW:0]   probe;
  logic [GW-1:0] idx;
  logic          found;

  // probe is one bit wider so rr_ptr + k never overflows before the wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    probe     = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = {1'b0, rr_ptr} + (GW+1)'(k);
      if (probe >= (GW+1)'(NUM_REQ)) probe = probe - (GW+1)'(NUM_REQ);
      idx = probe[GW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/ad5541_dac_sched.sv
// Round-robin update scheduler for the AD5541 DAC: grants a requester, launches its word into
// the SPI shifter, strobes LDAC and acks. Define AD5541_DAC_SCHED_RATE_LIMIT_EN for a MIN_GAP idle.
module ad5541_dac_sched
  import ad5541_pkg::*;
#(
  parameter int  NUM_REQ       = 4,
  parameter int  LDAC_WIDTH    = 4,
  parameter int  START_TIMEOUT = 64,
  parameter int  MIN_GAP       = 32,
  localparam int GW            = clog2_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [DAC_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     spi_dv,
  output logic [DAC_W-1:0]         spi_data,
  input  logic                     spi_csn,
  output logic                     ldac_n,
  output logic [GW-1:0]            grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  // A single phase counter times the launch window, the LDAC pulse and the optional gap.
  localparam int CNT_A   = (START_TIMEOUT > LDAC_WIDTH) ? START_TIMEOUT : LDAC_WIDTH;
  localparam int CNT_MAX = (CNT_A > MIN_GAP) ? CNT_A : MIN_GAP;
  localparam int CW      = clog2_w(CNT_MAX) + 1;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [GW-1:0]      rr_ptr;
  logic [GW-1:0]      arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic [DAC_W-1:0]   data_q;
  logic [DAC_W-1:0]   data_sel;
  logic               grant_now;
  logic               strobe_last;
  logic               start_expired;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_grant[i]) data_sel = data_sel | req_data[i*DAC_W +: DAC_W];
  end

  // Launch only with the shifter idle, so a transfer left running across reset is never overrun.
  assign grant_now     = (state == S_IDLE) && (|req) && spi_csn;
  assign strobe_last   = (state == S_STROBE) && (cnt == CW'(LDAC_WIDTH - 1));
  assign start_expired = (state == S_WAIT_START) && spi_csn && (cnt == CW'(START_TIMEOUT - 1));

  always_comb begin
    state_nxt   = state;
    ack         = '0;
    spi_dv      = 1'b0;
    spi_data    = data_q;
    ldac_n      = 1'b1;
    busy        = (state != S_IDLE);
    timeout_err = start_expired;
    case (state)
      S_IDLE:       if (grant_now) state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        spi_dv    = 1'b1;
        state_nxt = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!spi_csn)           state_nxt = S_WAIT_END;
        else if (start_expired) state_nxt = S_IDLE;
      end
      S_WAIT_END:   if (spi_csn) state_nxt = S_STROBE;
      S_STROBE: begin
        // Reset releases LDAC combinationally instead of waiting for the next edge.
        ldac_n = !reset_n;
        if (strobe_last) begin
          if (reset_n) ack[grant_id] = 1'b1;
`ifdef AD5541_DAC_SCHED_RATE_LIMIT_EN
          state_nxt = S_GAP;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef AD5541_DAC_SCHED_RATE_LIMIT_EN
      S_GAP:        if (cnt == CW'(MIN_GAP - 1)) state_nxt = S_IDLE;
`endif
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      data_q   <= '0;
      grant_id <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= ((state_nxt != state) || (state == S_IDLE)) ? '0 : cnt + 1'b1;
      if (grant_now) begin
        data_q   <= data_sel;
        grant_id <= arb_idx;
      end
      if (strobe_last)
        rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_ad5541_dac_sched.sv
// Bench for ad5541_dac_sched: directed scenarios plus randomized request traffic, checked against
// a round-robin priority model and a simple behavioural SPI shifter.
module tb_ad5541_dac_sched;

  localparam int N      = 4;
  localparam int LDAC_W = 4;
  localparam int TMO    = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [16*N-1:0] req_data;
  logic [N-1:0]  ack;
  logic          spi_dv;
  logic [15:0]   spi_data;
  logic          spi_csn;
  logic          ldac_n;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout_err;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit [N-1:0]  reqMask;
  logic [15:0] reqData [N];
  int          ptrModel;
  int          lastAckAt;
  bit          shifterOn = 1'b1;

  ad5541_dac_sched #(
    .NUM_REQ       (N),
    .LDAC_WIDTH    (LDAC_W),
    .START_TIMEOUT (TMO),
    .MIN_GAP       (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .spi_dv      (spi_dv),
    .spi_data    (spi_data),
    .spi_csn     (spi_csn),
    .ldac_n      (ldac_n),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shifter model: after each load strobe, chip-select drops after 1..4 cycles for 16..24 cycles.
  initial begin
    spi_csn = 1'b1;
    forever begin
      @(negedge clk);
      if (spi_dv === 1'b1 && shifterOn) begin
        repeat ($urandom_range(4, 1)) @(negedge clk);
        spi_csn = 1'b0;
        repeat ($urandom_range(24, 16)) @(negedge clk);
        spi_csn = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=expired required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus();
    req = reqMask;
    for (int i = 0; i < N; i++) req_data[16*i +: 16] = reqData[i];
  endtask

  // Reference arbitration: first pending requester at or after the pointer, wrapping.
  function automatic int pickWinner(input bit [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (((mask >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  task automatic serveOne(input string tag, input int winner, input bit backToBack, input bit withdraw);
    logic [15:0]  expData, dvData;
    logic [N-1:0] ackVal;
    logic [1:0]   dvGid;
    int dvCnt, lowRun, toCnt, dvAt, sinceDv;
    bit done;
    expData = reqData[winner];
    dvCnt = 0; lowRun = 0; toCnt = 0; dvAt = 0; sinceDv = -1; done = 1'b0;
    dvData = '0; dvGid = '0; ackVal = '0;
    for (int n = 0; n < 600 && !done; n++) begin
      @(negedge clk);
      if (spi_dv === 1'b1) begin
        dvCnt++; dvData = spi_data; dvGid = grant_id; dvAt = cyc; sinceDv = 0;
      end else if (sinceDv >= 0) sinceDv++;
      if (withdraw && sinceDv == 1) begin
        reqMask[winner] = 1'b0;
        reqData[winner] = 16'h0000;
        applyStimulus();
      end
      if (ldac_n === 1'b0) lowRun++;
      if (timeout_err === 1'b1) toCnt++;
      if (ack !== '0) begin
        ackVal = ack;
        done = 1'b1;
      end
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    if (!done) return;
    checkOutput({tag, "_dv_count"}, dvCnt, 1);
    checkOutput({tag, "_spi_data"}, dvData, expData);
    checkOutput({tag, "_grant_id"}, dvGid, winner);
    checkOutput({tag, "_ack"}, ackVal, 1 << winner);
    checkOutput({tag, "_ldac_low"}, lowRun, LDAC_W);
    checkOutput({tag, "_no_timeout"}, toCnt, 0);
    if (backToBack) begin
`ifdef AD5541_DAC_SCHED_RATE_LIMIT_EN
      checkOutput({tag, "_gap_min"}, 32'((dvAt - lastAckAt) >= 32), 32'd1);
`else
      checkOutput({tag, "_gap"}, dvAt - lastAckAt, 2);
`endif
    end
    lastAckAt = cyc;
  endtask

  initial begin
    int w, n, dvCnt, toCnt, dv1, dv2, to1, to2, dataBad;
    bit done;
    bit [N-1:0] add;
    logic [N-1:0] ackVal;

    reset_n = 1'b0;
    reqMask = '0;
    for (int i = 0; i < N; i++) reqData[i] = '0;
    applyStimulus();
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_spi_dv", spi_dv, 0);
    checkOutput("rst_spi_data", spi_data, 0);
    checkOutput("rst_ldac_n", ldac_n, 1);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    reset_n = 1'b1;
    ptrModel = 0;

    reqMask = 4'b0100; reqData[2] = 16'hA5C3; applyStimulus();
    serveOne("single", 2, 1'b0, 1'b0);
    ptrModel = 3;
    reqMask = '0; applyStimulus();

    reqMask = 4'b0010; reqData[1] = 16'h1234; applyStimulus();
    serveOne("withdraw", 1, 1'b0, 1'b1);
    ptrModel = 2;
    reqMask = '0; applyStimulus();

    // Contention from a freshly reset pointer: all four requesters held high.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ptrModel = 0;
    for (int i = 0; i < N; i++) reqData[i] = 16'($urandom);
    reqMask = 4'b1111; applyStimulus();
    for (int u = 0; u < 5; u++) begin
      w = pickWinner(reqMask, ptrModel);
      serveOne($sformatf("contend%0d", u), w, (u > 0), 1'b0);
      ptrModel = (w + 1) % N;
      reqData[w] = 16'($urandom);
      applyStimulus();
    end

    // Randomized traffic: served requester drops, new ones join, pending ones hold their data.
    for (int r = 0; r < 24; r++) begin
      w = pickWinner(reqMask, ptrModel);
      if (w < 0) break;
      serveOne($sformatf("rand%0d", r), w, 1'b1, 1'b0);
      ptrModel = (w + 1) % N;
      reqMask[w] = 1'b0;
      if (r < 18) begin
        add = N'($urandom);
        if ((reqMask | add) == '0) add = N'(1 << $urandom_range(N - 1, 0));
        for (int i = 0; i < N; i++)
          if (add[i] && !reqMask[i]) reqData[i] = 16'($urandom);
        reqMask = reqMask | add;
      end
      applyStimulus();
      if (reqMask == '0) break;
    end

    // Launch timeout with the shifter silent, retried until the shifter is re-enabled.
    shifterOn = 1'b0;
    reqMask = 4'b0001; reqData[0] = 16'($urandom); applyStimulus();
    dvCnt = 0; toCnt = 0; dv1 = 0; dv2 = 0; to1 = 0; to2 = 0; dataBad = 0;
    done = 1'b0; ackVal = '0;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      if (spi_dv === 1'b1) begin
        dvCnt++;
        if (dvCnt == 1) dv1 = cyc;
        if (dvCnt == 2) dv2 = cyc;
        if (spi_data !== reqData[0] || grant_id !== 2'd0) dataBad++;
      end
      if (timeout_err === 1'b1) begin
        toCnt++;
        if (toCnt == 1) to1 = cyc;
        if (toCnt == 2) begin
          to2 = cyc;
          shifterOn = 1'b1;
        end
      end
      if (ack !== '0) begin
        ackVal = ack;
        done = 1'b1;
      end
    end
    checkOutput("tmo_done", 32'(done), 32'd1);
    checkOutput("tmo_latency", to1 - dv1, TMO);
    checkOutput("tmo_relaunch", dv2 - to1, 2);
    checkOutput("tmo_count", toCnt, 2);
    checkOutput("tmo_dv_count", dvCnt, 3);
    checkOutput("tmo_same_req", dataBad, 0);
    checkOutput("tmo_ack", ackVal, 4'b0001);
    ptrModel = 1;
    reqMask = '0; applyStimulus();

    // Reset while the shifter is mid-transfer: no relaunch until chip-select returns high.
    reqMask = 4'b1000; reqData[3] = 16'($urandom); applyStimulus();
    n = 0;
    while (spi_csn === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wend_started", spi_csn, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("wend_rst_busy", busy, 0);
    checkOutput("wend_rst_ldac_n", ldac_n, 1);
    checkOutput("wend_rst_grant_id", grant_id, 0);
    reset_n = 1'b1;
    dvCnt = 0; n = 0;
    #1;
    while (spi_csn === 1'b0 && n < 100) begin
      @(negedge clk);
      #1;
      if (spi_dv === 1'b1) dvCnt++;
      n++;
    end
    checkOutput("wend_no_launch", dvCnt, 0);
    ptrModel = 0;
    serveOne("wend_retry", 3, 1'b0, 1'b0);
    reqMask = '0; applyStimulus();

    // Reset during the LDAC strobe releases ldac_n without waiting for a clock edge.
    reqMask = 4'b0001; reqData[0] = 16'($urandom); applyStimulus();
    n = 0;
    while (ldac_n === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("strb_entered", ldac_n, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("strb_ldac_release", ldac_n, 1);
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("strb_rst_busy", busy, 0);
    serveOne("strb_retry", 0, 1'b0, 1'b0);
    reqMask = '0; applyStimulus();

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
